// File: rtl/contador_mod_param_if.sv
// Control/status bundle for contador_mod_param: the counter takes the slave modport,
// whoever drives the enables and loads takes the master modport.
interface contador_mod_param_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, clr, load, load_val, ovf_clr,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, ovf_clr,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/contador_mod_param.sv
// Modulo up/down counter with enable prescaler, load/clear, cascade tc, wrap pulse, sticky ovf.
// Define CONTADOR_MOD_SAT_EN to saturate at 0 / MODULO-1 instead of wrapping around.
module contador_mod_param #(
    parameter int WIDTH  = 5,
    parameter int MODULO = 28,
    parameter int PRESC  = 1
) (
    input  logic                clk,
    input  logic                reset_clk,
    contador_mod_param_if.slave bus
);
    localparam int               PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESC - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step_due;
    logic             at_term;

    always_comb begin
        step_due = bus.en && (presc_q == PRE_LAST);
        at_term  = bus.up_dn ? (count_q == CNT_MAX) : (count_q == '0);
    end

    // tc is purely combinational so a downstream stage can step on the same edge as our wrap
    assign bus.tc    = step_due && at_term;
    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            presc_d = '0;
        end else if (bus.load) begin
            count_d = ({1'b0, bus.load_val} >= MOD_EXT) ? CNT_MAX : bus.load_val;
            presc_d = '0;
        end else if (bus.en) begin
            if (step_due) begin
                presc_d = '0;
                if (at_term) begin
                    wrap_d = 1'b1;
`ifdef CONTADOR_MOD_SAT_EN
                    count_d = count_q;
`else
                    count_d = bus.up_dn ? '0 : CNT_MAX;
`endif
                end else begin
                    count_d = bus.up_dn ? count_q + 1'b1 : count_q - 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        ovf_d = (ovf_q && !bus.ovf_clr) || wrap_d;
    end

    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            count_q <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
